// File: rtl/hub75_tx.sv
// HUB75 LED-panel row transmitter: shifts one row pair of pixels, blanks, latches,
// then enables the outputs for a fixed on-time before the next row.
module hub75_tx #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned ROW_BITS  = 4,
  parameter int unsigned ON_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [2:0]                 rgb0,
  input  logic [2:0]                 rgb1,
  output logic [$clog2(WIDTH)-1:0]   pix_col,
  output logic [ROW_BITS-1:0]        pix_row,
  output logic [2:0]                 p_rgb0,
  output logic [2:0]                 p_rgb1,
  output logic                       p_clk,
  output logic                       p_lat,
  output logic                       p_oe_n,
  output logic [ROW_BITS-1:0]        p_addr
);

  localparam int unsigned ColW = $clog2(WIDTH);
  localparam logic [ColW-1:0] LastCol = ColW'(WIDTH - 1);
  localparam logic [15:0]     LastOn  = 16'(ON_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StShiftLo, StShiftHi, StBlank, StLatch, StDisplay
  } state_e;

  state_e              state_q, state_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [ROW_BITS-1:0] addr_q, addr_d;
  logic [2:0]          rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic [15:0]         on_cnt_q, on_cnt_d;
  logic                pix_ready_q, pix_ready_d;
  logic                p_clk_q, p_clk_d;
  logic                p_lat_q, p_lat_d;
  logic                p_oe_n_q, p_oe_n_d;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    rgb0_d   = rgb0_q;
    rgb1_d   = rgb1_q;
    on_cnt_d = on_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StShiftLo;
          col_d   = '0;
        end
      end
      StShiftLo: begin
        if (pix_valid && pix_ready_q) begin
          rgb0_d  = rgb0;
          rgb1_d  = rgb1;
          state_d = StShiftHi;
        end
      end
      StShiftHi: begin
        if (col_q == LastCol) begin
          state_d = StBlank;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = StShiftLo;
        end
      end
      StBlank: state_d = StLatch;
      StLatch: begin
        // The shifted row becomes the displayed row; next row to shift wraps naturally.
        addr_d   = row_q;
        row_d    = row_q + 1'b1;
        on_cnt_d = '0;
        state_d  = StDisplay;
      end
      StDisplay: begin
        if (on_cnt_q == LastOn) begin
          on_cnt_d = '0;
          col_d    = '0;
          state_d  = en ? StShiftLo : StIdle;
        end else begin
          on_cnt_d = on_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so the registers track the state exactly.
    pix_ready_d = (state_d == StShiftLo);
    p_clk_d     = (state_d == StShiftHi);
    p_lat_d     = (state_d == StLatch);
    p_oe_n_d    = (state_d != StDisplay);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      rgb0_q      <= '0;
      rgb1_q      <= '0;
      on_cnt_q    <= '0;
      pix_ready_q <= 1'b0;
      p_clk_q     <= 1'b0;
      p_lat_q     <= 1'b0;
      p_oe_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      rgb0_q      <= rgb0_d;
      rgb1_q      <= rgb1_d;
      on_cnt_q    <= on_cnt_d;
      pix_ready_q <= pix_ready_d;
      p_clk_q     <= p_clk_d;
      p_lat_q     <= p_lat_d;
      p_oe_n_q    <= p_oe_n_d;
    end
  end

  assign pix_ready = pix_ready_q;
  assign pix_col   = col_q;
  assign pix_row   = row_q;
  assign p_rgb0    = rgb0_q;
  assign p_rgb1    = rgb1_q;
  assign p_clk     = p_clk_q;
  assign p_lat     = p_lat_q;
  assign p_oe_n    = p_oe_n_q;
  assign p_addr    = addr_q;

endmodule
